// File: rtl/rice_core_csr_access_unit_if.sv
// CSR bus interface: request channel (address/strobe/write_data) and response channel
// (read_data/error), each with its own valid/ready pair.
interface rice_bus_if #(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     request_valid;
  logic                     request_ready;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [XLEN/8-1:0]        strobe;
  logic [XLEN-1:0]          write_data;
  logic                     response_valid;
  logic                     response_ready;
  logic [XLEN-1:0]          read_data;
  logic                     error;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_core_csr_access_unit.sv
// Zicsr access sequencer: runs CSRRW/RS/RC and immediate forms as read, write or RMW bus
// transactions. Response timeout and drain are built only with RICE_CORE_CSR_ACCESS_TIMEOUT_EN.
package rice_core_pkg;
  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } rice_core_csr_access;

  typedef logic [4:0] rice_riscv_rs;
endpackage

module rice_core_csr_access_unit
  import rice_core_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  rice_core_csr_access      i_csr_access,
  input  rice_riscv_rs             i_rs1,
  input  rice_riscv_rs             i_rd,
  input  logic [XLEN-1:0]          i_rs1_value,
  input  logic [ADDRESS_WIDTH-1:0] i_csr_address,
  input  logic [1:0]               i_privilege,
  output logic                     o_done,
  output logic [XLEN-1:0]          o_read_data,
  output logic                     o_error,
  output logic                     o_illegal,
  output logic                     o_timeout,
  rice_bus_if.master               csr_if
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ILLEGAL = 3'd1;
  localparam logic [2:0] ST_READ    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
`ifdef RICE_CORE_CSR_ACCESS_TIMEOUT_EN
  localparam logic [2:0] ST_DRAIN   = 3'd4;
`endif

  logic [2:0]               state;
  logic [1:0]               op_kind;
  logic [XLEN-1:0]          operand;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     do_read;
  logic                     do_write;
  logic                     req_valid;
  logic                     req_sent;
  logic                     req_acked;
  logic [XLEN-1:0]          read_value;
  logic                     done;
  logic [XLEN-1:0]          result;
  logic                     error_flag;
  logic                     illegal_flag;
  logic                     timeout_flag;

  logic [2:0]      acc_bits;
  logic            acc_is_rw;
  logic            acc_do_read;
  logic            acc_do_write;
  logic            acc_illegal;
  logic [XLEN-1:0] acc_operand;
  logic            in_bus;
  logic            request_ack;
  logic            response_ack;
  logic            tmo_hit;

  function automatic logic [XLEN-1:0] merge_wdata(input logic [1:0]      kind,
                                                  input logic [XLEN-1:0] r,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] w;
    case (kind)
      2'b10:   w = r | d;
      2'b11:   w = r & ~d;
      default: w = d;
    endcase
    return w;
  endfunction

  // Suppression follows the register indices, not the operand value.
  assign acc_bits     = i_csr_access;
  assign acc_is_rw    = (acc_bits[1:0] == 2'b01);
  assign acc_do_read  = !(acc_is_rw && (i_rd == 5'd0));
  assign acc_do_write = acc_is_rw || (i_rs1 != 5'd0);
  assign acc_operand  = acc_bits[2] ? {{(XLEN-5){1'b0}}, i_rs1} : i_rs1_value;

  generate
    if (ADDRESS_WIDTH >= 12) begin : g_priv_check
      assign acc_illegal = (i_csr_address[9:8] > i_privilege) ||
                           (acc_do_write && (i_csr_address[11:10] == 2'b11));
    end else begin : g_no_priv_check
      assign acc_illegal = 1'b0;
    end
  endgenerate

  assign in_bus       = (state == ST_READ) || (state == ST_WRITE);
  assign request_ack  = req_valid && csr_if.request_ready;
  assign response_ack = csr_if.response_valid && csr_if.response_ready;

`ifdef RICE_CORE_CSR_ACCESS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_counting;

  assign tmo_counting = in_bus && req_sent && (req_valid || !response_ack);
  assign tmo_hit      = tmo_counting && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter, restarted whenever a new request is raised.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if (in_bus && !req_sent) begin
      tmo_cnt <= '0;
    end else if (tmo_counting) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  assign csr_if.response_ready = (in_bus || (state == ST_DRAIN)) && !req_valid;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg        = (TIMEOUT_CYCLES > 0);
  assign tmo_hit               = 1'b0;
  assign csr_if.response_ready = in_bus && !req_valid;
`endif

  assign csr_if.request_valid = req_valid;
  assign csr_if.address       = address;
  assign csr_if.strobe        = (state == ST_WRITE) ? {(XLEN/8){1'b1}} : {(XLEN/8){1'b0}};
  assign csr_if.write_data    = merge_wdata(op_kind, read_value, operand);

  assign o_ready     = (state == ST_IDLE);
  assign o_done      = done;
  assign o_read_data = result;
  assign o_error     = error_flag;
  assign o_illegal   = illegal_flag;
  assign o_timeout   = timeout_flag;

  // Sequencer: command capture, bus handshakes and registered completion reporting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      op_kind      <= 2'b00;
      operand      <= '0;
      address      <= '0;
      do_read      <= 1'b0;
      do_write     <= 1'b0;
      req_valid    <= 1'b0;
      req_sent     <= 1'b0;
      req_acked    <= 1'b0;
      read_value   <= '0;
      done         <= 1'b0;
      result       <= '0;
      error_flag   <= 1'b0;
      illegal_flag <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_kind   <= acc_bits[1:0];
            operand   <= acc_operand;
            address   <= i_csr_address;
            do_read   <= acc_do_read;
            do_write  <= acc_do_write;
            req_sent  <= 1'b0;
            req_acked <= 1'b0;
            if (acc_illegal) begin
              state <= ST_ILLEGAL;
            end else if (acc_do_read) begin
              state <= ST_READ;
            end else begin
              state <= ST_WRITE;
            end
          end
        end
        ST_ILLEGAL: begin
          done         <= 1'b1;
          result       <= '0;
          error_flag   <= 1'b1;
          illegal_flag <= 1'b1;
          timeout_flag <= 1'b0;
          state        <= ST_IDLE;
        end
        ST_READ, ST_WRITE: begin
          if (!req_sent) begin
            req_valid <= 1'b1;
            req_sent  <= 1'b1;
          end else if (tmo_hit) begin
            req_valid    <= 1'b0;
            req_acked    <= req_acked || request_ack;
            done         <= 1'b1;
            result       <= '0;
            error_flag   <= 1'b1;
            illegal_flag <= 1'b0;
            timeout_flag <= 1'b1;
`ifdef RICE_CORE_CSR_ACCESS_TIMEOUT_EN
            state        <= ST_DRAIN;
`else
            state        <= ST_IDLE;
`endif
          end else begin
            if (request_ack) begin
              req_valid <= 1'b0;
              req_acked <= 1'b1;
            end
            if (response_ack) begin
              // A clean read with a pending write turns into the write phase of the RMW.
              if ((state == ST_READ) && !csr_if.error && do_write) begin
                read_value <= csr_if.read_data;
                req_sent   <= 1'b0;
                req_acked  <= 1'b0;
                state      <= ST_WRITE;
              end else begin
                done         <= 1'b1;
                error_flag   <= csr_if.error;
                illegal_flag <= 1'b0;
                timeout_flag <= 1'b0;
                if (state == ST_READ) begin
                  result <= csr_if.error ? '0 : csr_if.read_data;
                end else begin
                  result <= do_read ? read_value : '0;
                end
                state <= ST_IDLE;
              end
            end
          end
        end
`ifdef RICE_CORE_CSR_ACCESS_TIMEOUT_EN
        ST_DRAIN: begin
          if (!req_acked || response_ack) begin
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
